fir: RTL and testbench



---
 rtl/fir_if.sv | 12 +
 rtl/fir.sv | 76 +++++++
 tb/tb_fir.sv | 139 +++++++++++++
 3 files changed

// File: rtl/fir_if.sv
// Sample stream bus between a PCM source, the FIR filter and a downstream sink.
// The master drives samples in and the slave returns filtered samples.
interface fir_if #(
   parameter int unsigned WD_IN  = 24,
   parameter int unsigned WD_OUT = 24
);
   logic signed [WD_IN-1:0]  data_in;
   logic signed [WD_OUT-1:0] data_out;

   modport master (output data_in, input data_out);
   modport slave  (input data_in, output data_out);
endinterface

// File: rtl/fir.sv
// 16-tap direct-form low-pass FIR with fixed symmetric Q1.15 coefficients.
// Full-precision accumulate, round half toward +inf, saturate to WD_OUT bits.
module fir #(
   parameter int unsigned WD_IN   = 24,
   parameter int unsigned WD_OUT  = 24,
   parameter int unsigned WD_COEF = 16
) (
   input  logic  clk,
   input  logic  reset,
   fir_if.slave  bus
);
   localparam int unsigned NTAPS = 16;
   localparam int unsigned AccW  = WD_IN + WD_COEF + 4;
   localparam int unsigned RndW  = AccW - 15;

   localparam logic signed [WD_COEF-1:0] COEF [NTAPS] = '{
      -16'sd120, -16'sd250, 16'sd0,    16'sd900,  16'sd2200, 16'sd3800, 16'sd4554, 16'sd5300,
      16'sd5300, 16'sd4554, 16'sd3800, 16'sd2200, 16'sd900,  16'sd0,    -16'sd250, -16'sd120
   };

   localparam logic signed [AccW-1:0] Half = AccW'(1 << 14);
   localparam logic signed [RndW-1:0] YMax = RndW'((2 ** (WD_OUT - 1)) - 1);
   localparam logic signed [RndW-1:0] YMin = -(RndW'(2 ** (WD_OUT - 1)));

   logic signed [WD_IN-1:0]  taps_q [NTAPS];
   logic signed [WD_IN-1:0]  taps_d [NTAPS];
   logic signed [WD_OUT-1:0] data_out_q, data_out_d;

   logic signed [AccW-1:0] acc;
   logic signed [AccW-1:0] tap_ext, coef_ext;
   logic signed [RndW-1:0] y_r;

   always_comb begin
      taps_d[0] = bus.data_in;
      for (int i = 1; i < NTAPS; i++) begin
         taps_d[i] = taps_q[i-1];
      end
   end

   // Output uses the tap values present before the edge, so a new sample
   // reaches data_out one edge after it is captured.
   always_comb begin
      acc      = '0;
      tap_ext  = '0;
      coef_ext = '0;
      for (int i = 0; i < NTAPS; i++) begin
         tap_ext  = AccW'(taps_q[i]);
         coef_ext = AccW'(COEF[i]);
         acc      = acc + tap_ext * coef_ext;
      end
      y_r = RndW'((acc + Half) >>> 15);
      if (y_r > YMax) begin
         data_out_d = {1'b0, {(WD_OUT-1){1'b1}}};
      end else if (y_r < YMin) begin
         data_out_d = {1'b1, {(WD_OUT-1){1'b0}}};
      end else begin
         data_out_d = y_r[WD_OUT-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NTAPS; i++) begin
            taps_q[i] <= '0;
         end
         data_out_q <= '0;
      end else begin
         for (int i = 0; i < NTAPS; i++) begin
            taps_q[i] <= taps_d[i];
         end
         data_out_q <= data_out_d;
      end
   end

   assign bus.data_out = data_out_q;
endmodule

// File: tb/tb_fir.sv
// Self-checking bench for fir: directed and random streams against an
// arithmetic model of the filter, plus literal expectations for key cases.
module tb_fir;
   logic clk = 1'b0;
   logic reset;

   fir_if #(.WD_IN(24), .WD_OUT(24)) bus ();

   fir #(.WD_IN(24), .WD_OUT(24), .WD_COEF(16)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   int coef [16] = '{-120, -250, 0, 900, 2200, 3800, 4554, 5300,
                     5300, 4554, 3800, 2200, 900, 0, -250, -120};

   // hist[0] is the most recently captured sample
   logic signed [23:0] hist [16];
   logic [23:0] exp_out;

   function automatic logic [23:0] model_out();
      longint acc = 0;
      longint y;
      for (int i = 0; i < 16; i++) begin
         acc += longint'(coef[i]) * longint'(hist[i]);
      end
      y = (acc + 16384) >>> 15;
      if (y > 64'sd8388607) return 24'h7FFFFF;
      if (y < -64'sd8388608) return 24'h800000;
      return y[23:0];
   endfunction

   task automatic chk(input string name, input logic [23:0] act, input logic [23:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: data_out=%h required=%h at t=%0t", name, act, req, $time);
      end
   endtask

   // One clock edge: drive inputs, advance the model, compare every cycle.
   task automatic step(input logic rst, input logic [23:0] din);
      reset = rst;
      bus.data_in = din;
      @(posedge clk);
      exp_out = rst ? 24'h0 : model_out();
      if (rst) begin
         for (int i = 0; i < 16; i++) hist[i] = '0;
      end else begin
         for (int i = 15; i > 0; i--) hist[i] = hist[i-1];
         hist[0] = din;
      end
      #1;
      chk("model", bus.data_out, exp_out);
   endtask

   initial begin
      logic [23:0] pos_v, neg_v, s;
      real ph;
      for (int i = 0; i < 16; i++) hist[i] = '0;

      // Reset holds output at zero regardless of data_in
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 24'h123456);
         chk("reset_hold", bus.data_out, 24'h000000);
      end
      step(1'b0, 24'h000000);
      chk("reset_after", bus.data_out, 24'h000000);

      // Impulse of 1.0 in Q1.15 walks out the coefficients
      step(1'b0, 24'h008000);
      step(1'b0, 24'h0); chk("imp_c0", bus.data_out, 24'hFFFF88);
      step(1'b0, 24'h0); chk("imp_c1", bus.data_out, 24'hFFFF06);
      step(1'b0, 24'h0); chk("imp_c2", bus.data_out, 24'h000000);
      step(1'b0, 24'h0); chk("imp_c3", bus.data_out, 24'h000384);
      for (int i = 4; i < 16; i++) step(1'b0, 24'h0);
      chk("imp_c15", bus.data_out, 24'hFFFF88);
      step(1'b0, 24'h0); chk("imp_tail", bus.data_out, 24'h000000);

      // DC gain is exactly one
      step(1'b1, 24'h0);
      for (int i = 0; i < 17; i++) step(1'b0, 24'h100000);
      chk("dc_pos", bus.data_out, 24'h100000);
      step(1'b1, 24'h0);
      for (int i = 0; i < 17; i++) step(1'b0, 24'hF00000);
      chk("dc_neg", bus.data_out, 24'hF00000);

      // Worst-case sign-matched pattern saturates both ways
      for (int p = 0; p < 2; p++) begin
         step(1'b1, 24'h0);
         for (int j = 0; j < 16; j++) begin
            pos_v = (p == 0) ? 24'h7FFFFF : 24'h800000;
            neg_v = (p == 0) ? 24'h800000 : 24'h7FFFFF;
            s = (coef[15-j] > 0) ? pos_v : ((coef[15-j] < 0) ? neg_v : 24'h0);
            step(1'b0, s);
         end
         step(1'b0, 24'h0);
         chk(p == 0 ? "sat_pos" : "sat_neg", bus.data_out, p == 0 ? 24'h7FFFFF : 24'h800000);
      end

      // Rounding: tiny impulses
      step(1'b1, 24'h0);
      step(1'b0, 24'h000001);
      for (int i = 0; i < 17; i++) begin
         step(1'b0, 24'h0);
         chk("round_one", bus.data_out, 24'h000000);
      end
      step(1'b0, 24'h000004);
      for (int i = 0; i < 8; i++) step(1'b0, 24'h0);
      chk("round_c7", bus.data_out, 24'h000001);
      for (int i = 0; i < 9; i++) step(1'b0, 24'h0);

      // Sine at fs/64 with a mid-stream reset
      for (int n = 0; n < 200; n++) begin
         ph = 2.0 * 3.14159265358979 * real'(n) / 64.0;
         s = 24'($rtoi(4194304.0 * $sin(ph) + (($sin(ph) >= 0.0) ? 0.5 : -0.5)));
         if (n == 120) begin
            step(1'b1, s);
            chk("sine_reset", bus.data_out, 24'h000000);
         end else begin
            step(1'b0, s);
         end
      end

      // Random full-range stream with occasional resets
      for (int n = 0; n < 400; n++) begin
         step(($urandom_range(0, 49) == 0), 24'($urandom));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
